// File: rtl/rr_arbiter4.sv
// Four-way round-robin arbiter with a bounded owner tenure.
// The current owner is held as a 2-bit index plus a valid state; the one-hot
// grant is decoded from those registers only, so no input reaches an output
// without passing through a flop.
module rr_arbiter4 #(
   parameter int MAX_HOLD = 4,
   parameter int HOLD_W   = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   input  logic [3:0] req,
   output logic [3:0] gnt,
   output logic [1:0] gnt_idx,
   output logic       gnt_valid,
   output logic       busy
);

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   localparam logic [HOLD_W-1:0] HOLD_LIMIT = HOLD_W'(MAX_HOLD);
   localparam logic [HOLD_W-1:0] HOLD_ONE   = HOLD_W'(1);

   state_t            state, state_next;
   logic [1:0]        ptr, ptr_next;
   logic [1:0]        idx_next;
   logic [HOLD_W-1:0] hold_cnt, hold_next;
   logic [3:0]        owner_mask;
   logic [1:0]        after_owner;

   // First set request bit when scanning base, base+1, base+2, base+3 (wrapping).
   // Scanning from the far end backwards leaves the nearest hit as the result.
   function automatic logic [1:0] pick(input logic [3:0] r, input logic [1:0] base);
      logic [1:0] cand;
      logic [1:0] result;
      result = base;
      for (int k = 3; k >= 0; k--) begin
         cand = base + 2'(k);
         if (r[cand]) begin
            result = cand;
         end
      end
      return result;
   endfunction

   assign owner_mask  = 4'b0001 << gnt_idx;
   assign after_owner = gnt_idx + 2'd1;

   // Next owner, pointer and tenure counter; release beats drop beats preempt beats keep.
   always_comb begin
      state_next = state;
      ptr_next   = ptr;
      idx_next   = gnt_idx;
      hold_next  = hold_cnt;
      case (state)
         IDLE: begin
            if (en && (req != 4'b0000)) begin
               state_next = GRANT;
               idx_next   = pick(req, ptr);
               hold_next  = HOLD_ONE;
            end
         end
         GRANT: begin
            if (!en) begin
               state_next = IDLE;
               ptr_next   = after_owner;
               hold_next  = '0;
            end else if ((req & owner_mask) == 4'b0000) begin
               ptr_next = after_owner;
               if (req != 4'b0000) begin
                  idx_next  = pick(req, after_owner);
                  hold_next = HOLD_ONE;
               end else begin
                  state_next = IDLE;
                  hold_next  = '0;
               end
            end else if ((hold_cnt == HOLD_LIMIT) && ((req & ~owner_mask) != 4'b0000)) begin
               ptr_next  = after_owner;
               idx_next  = pick(req, after_owner);
               hold_next = HOLD_ONE;
            end else if (hold_cnt < HOLD_LIMIT) begin
               hold_next = hold_cnt + HOLD_ONE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // State, pointer, owner index and tenure registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         ptr      <= 2'd0;
         gnt_idx  <= 2'd0;
         hold_cnt <= '0;
      end else begin
         state    <= state_next;
         ptr      <= ptr_next;
         gnt_idx  <= idx_next;
         hold_cnt <= hold_next;
      end
   end

   assign gnt_valid = (state == GRANT);
   assign busy      = gnt_valid;
   assign gnt       = gnt_valid ? owner_mask : 4'b0000;

endmodule

// File: tb/tb_rr_arbiter4.sv
// Directed bench for rr_arbiter4: a cycle-by-cycle vector table followed by
// hand-written sequences for hold-limit alternation, saturation, release and reset.
module tb_rr_arbiter4;

   logic       clk;
   logic       rst;
   logic       en;
   logic [3:0] req;
   logic [3:0] gnt;
   logic [1:0] gnt_idx;
   logic       gnt_valid;
   logic       busy;

   int n_compared;
   int n_mismatched;

   typedef struct {
      logic       rst;
      logic       en;
      logic [3:0] req;
      logic [3:0] exp_gnt;
      logic [1:0] exp_idx;
      logic       exp_valid;
   } vec_t;

   vec_t vecs[14];

   rr_arbiter4 #(.MAX_HOLD(4), .HOLD_W(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .req       (req),
      .gnt       (gnt),
      .gnt_idx   (gnt_idx),
      .gnt_valid (gnt_valid),
      .busy      (busy)
   );

   // Free-running 10-unit clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Drive inputs, then let exactly one rising edge sample them; return 1 unit after it.
   task automatic applyStimulus(input logic r, input logic e, input logic [3:0] q);
      rst = r;
      en  = e;
      req = q;
      @(posedge clk);
      #1;
   endtask

   // Compare every output against the expected owner and validity.
   task automatic checkOutput(input string name, input logic [3:0] exp_gnt,
                              input logic [1:0] exp_idx, input logic exp_valid);
      n_compared++;
      if (gnt !== exp_gnt) begin
         n_mismatched++;
         $display("[TB] FAIL %s gnt: got %b expected %b", name, gnt, exp_gnt);
      end
      n_compared++;
      if (gnt_idx !== exp_idx) begin
         n_mismatched++;
         $display("[TB] FAIL %s gnt_idx: got %b expected %b", name, gnt_idx, exp_idx);
      end
      n_compared++;
      if (gnt_valid !== exp_valid) begin
         n_mismatched++;
         $display("[TB] FAIL %s gnt_valid: got %b expected %b", name, gnt_valid, exp_valid);
      end
      n_compared++;
      if (busy !== exp_valid) begin
         n_mismatched++;
         $display("[TB] FAIL %s busy: got %b expected %b", name, busy, exp_valid);
      end
   endtask

   // Table of single-cycle vectors, then directed multi-cycle sequences.
   initial begin
      n_compared   = 0;
      n_mismatched = 0;
      rst = 1'b1;
      en  = 1'b0;
      req = 4'b0000;

      vecs[0]  = '{1'b1, 1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0};
      vecs[1]  = '{1'b0, 1'b1, 4'b0000, 4'b0000, 2'd0, 1'b0};
      vecs[2]  = '{1'b0, 1'b1, 4'b0000, 4'b0000, 2'd0, 1'b0};
      vecs[3]  = '{1'b0, 1'b1, 4'b0000, 4'b0000, 2'd0, 1'b0};
      vecs[4]  = '{1'b0, 1'b1, 4'b0000, 4'b0000, 2'd0, 1'b0};
      vecs[5]  = '{1'b0, 1'b1, 4'b0000, 4'b0000, 2'd0, 1'b0};
      vecs[6]  = '{1'b0, 1'b1, 4'b1010, 4'b0010, 2'd1, 1'b1};
      vecs[7]  = '{1'b0, 1'b1, 4'b1000, 4'b1000, 2'd3, 1'b1};
      vecs[8]  = '{1'b0, 1'b1, 4'b0000, 4'b0000, 2'd3, 1'b0};
      vecs[9]  = '{1'b0, 1'b1, 4'b0010, 4'b0010, 2'd1, 1'b1};
      vecs[10] = '{1'b0, 1'b0, 4'b0010, 4'b0000, 2'd1, 1'b0};
      vecs[11] = '{1'b0, 1'b1, 4'b0001, 4'b0001, 2'd0, 1'b1};
      vecs[12] = '{1'b1, 1'b1, 4'b1111, 4'b0000, 2'd0, 1'b0};
      vecs[13] = '{1'b0, 1'b0, 4'b1111, 4'b0000, 2'd0, 1'b0};

      for (int i = 0; i < 14; i++) begin
         applyStimulus(vecs[i].rst, vecs[i].en, vecs[i].req);
         checkOutput($sformatf("vec%0d", i), vecs[i].exp_gnt, vecs[i].exp_idx, vecs[i].exp_valid);
      end

      // Two contenders alternate every MAX_HOLD cycles.
      applyStimulus(1'b1, 1'b0, 4'b0000);
      for (int c = 0; c < 12; c++) begin
         applyStimulus(1'b0, 1'b1, 4'b0011);
         if ((c / 4) % 2 == 0) begin
            checkOutput($sformatf("alt%0d", c), 4'b0001, 2'd0, 1'b1);
         end else begin
            checkOutput($sformatf("alt%0d", c), 4'b0010, 2'd1, 1'b1);
         end
      end

      // Sole requester keeps the grant; a newcomer takes over at once once hold is saturated.
      applyStimulus(1'b1, 1'b0, 4'b0000);
      for (int c = 0; c < 20; c++) begin
         applyStimulus(1'b0, 1'b1, 4'b0100);
         checkOutput($sformatf("sole%0d", c), 4'b0100, 2'd2, 1'b1);
      end
      applyStimulus(1'b0, 1'b1, 4'b0101);
      checkOutput("sat_preempt", 4'b0001, 2'd0, 1'b1);

      // Disable release moves the pointer past owner 2.
      applyStimulus(1'b1, 1'b0, 4'b0000);
      applyStimulus(1'b0, 1'b1, 4'b0100);
      checkOutput("own2", 4'b0100, 2'd2, 1'b1);
      applyStimulus(1'b0, 1'b0, 4'b0100);
      checkOutput("en_release", 4'b0000, 2'd2, 1'b0);
      applyStimulus(1'b0, 1'b1, 4'b1111);
      checkOutput("after_release", 4'b1000, 2'd3, 1'b1);

      // Reset during a grant clears everything including the pointer.
      applyStimulus(1'b1, 1'b1, 4'b1111);
      checkOutput("rst_in_grant", 4'b0000, 2'd0, 1'b0);
      applyStimulus(1'b0, 1'b1, 4'b1111);
      checkOutput("after_rst", 4'b0001, 2'd0, 1'b1);

      // Mid-cycle request glitch is ignored; only the edge-sampled value counts.
      applyStimulus(1'b1, 1'b0, 4'b0000);
      rst = 1'b0;
      en  = 1'b1;
      req = 4'b0100;
      #3;
      req = 4'b0000;
      @(posedge clk);
      #1;
      checkOutput("glitch_ignored", 4'b0000, 2'd0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule
